// File: rtl/ddr_rd_arbiter_pkg.sv
// Shared types and global widths for the DDR read arbiter slice.
// DDR_ADDR_W / BURST_W are the global descriptor widths.
package ddr_rd_arbiter_pkg;

  localparam int unsigned DDR_ADDR_W = 32;
  localparam int unsigned BURST_W    = 8;

  // One DDR read descriptor as handed to the read engine.
  typedef struct packed {
    logic [DDR_ADDR_W-1:0] st_addr;
    logic [BURST_W-1:0]    burst;
    logic [DDR_ADDR_W-1:0] step;
    logic [BURST_W-1:0]    burst_num;
  } ddr_desc_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StBusy,
    StDone
  } arb_state_t;

endpackage

// File: rtl/ddr_rd_arbiter_if.sv
// Requester and DDR-engine bundle for the read arbiter.
// master: the arbiter itself; slave: requesters plus read engine.
interface ddr_rd_arbiter_if #(
  parameter int unsigned REQ_NUM = 4
);
  import ddr_rd_arbiter_pkg::*;

  localparam int unsigned IdW = $clog2(REQ_NUM);

  // Requester side, packed with requester i at slice i
  logic [REQ_NUM-1:0]            req_valid;
  logic [REQ_NUM-1:0]            req_ready;
  logic [REQ_NUM*DDR_ADDR_W-1:0] req_st_addr;
  logic [REQ_NUM*BURST_W-1:0]    req_burst;
  logic [REQ_NUM*DDR_ADDR_W-1:0] req_step;
  logic [REQ_NUM*BURST_W-1:0]    req_burst_num;
  logic [REQ_NUM-1:0]            req_done;

  // Engine side
  logic                  ddr_start;
  logic                  ddr_done;
  logic [DDR_ADDR_W-1:0] ddr_st_addr;
  logic [BURST_W-1:0]    ddr_burst;
  logic [DDR_ADDR_W-1:0] ddr_step;
  logic [BURST_W-1:0]    ddr_burst_num;

  // Status
  logic [IdW-1:0] grant_id;
  logic           busy;
  logic           err_timeout;

  modport master (
    input  req_valid, req_st_addr, req_burst, req_step, req_burst_num, ddr_done,
    output req_ready, req_done, ddr_start, ddr_st_addr, ddr_burst, ddr_step,
           ddr_burst_num, grant_id, busy, err_timeout
  );

  modport slave (
    output req_valid, req_st_addr, req_burst, req_step, req_burst_num, ddr_done,
    input  req_ready, req_done, ddr_start, ddr_st_addr, ddr_burst, ddr_step,
           ddr_burst_num, grant_id, busy, err_timeout
  );

endinterface

// File: rtl/ddr_rd_arbiter_rr_pick.sv
// Combinational rotating-priority selector: the first set request found when
// scanning ptr_i, ptr_i+1, ... (mod REQ_NUM) wins. REQ_NUM must be a power of
// two so the index addition wraps naturally.
module ddr_rd_arbiter_rr_pick #(
  parameter int unsigned REQ_NUM = 4,
  parameter int unsigned IdW     = $clog2(REQ_NUM)
) (
  input  logic [REQ_NUM-1:0] req_i,
  input  logic [IdW-1:0]     ptr_i,
  output logic [IdW-1:0]     idx_o,
  output logic               any_o
);

  logic [IdW-1:0] cand;

  // Scan from the farthest offset back to the pointer so the nearest hit wins.
  always_comb begin
    idx_o = '0;
    cand  = '0;
    any_o = |req_i;
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      cand = ptr_i + IdW'(i);
      if (req_i[cand]) idx_o = cand;
    end
  end

endmodule

// File: rtl/ddr_rd_arbiter.sv
// Round-robin arbiter sharing one DDR read engine among REQ_NUM requesters.
// One transaction in flight; the winner's descriptor is registered and the
// engine launched with a one-cycle start pulse, completion is routed back to
// the owner. Optional watchdog compiled in with `define DDR_ARB_TIMEOUT_EN.
module ddr_rd_arbiter
  import ddr_rd_arbiter_pkg::*;
#(
  parameter int unsigned REQ_NUM = 4,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst,
  ddr_rd_arbiter_if.master   bus_io
);

  localparam int unsigned IdW = $clog2(REQ_NUM);

  if (REQ_NUM < 2 || REQ_NUM > 8 || TIMEOUT < 2) begin : g_param_chk
    $error("ddr_rd_arbiter: REQ_NUM must be 2..8 and TIMEOUT at least 2");
  end

  arb_state_t         state_q;
  logic [IdW-1:0]     rr_ptr_q;
  logic [IdW-1:0]     grant_q;
  ddr_desc_t          desc_q;
  logic               ddr_start_q;
  logic               busy_q;
  logic [REQ_NUM-1:0] req_ready_q;
  logic [REQ_NUM-1:0] req_done_q;

  logic [IdW-1:0]     pick_idx;
  logic               pick_any;
  ddr_desc_t          pick_desc;
  int unsigned        sel;

`ifdef DDR_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT);
  logic [CntW-1:0] tmo_cnt_q;
  logic            err_q;
`endif

  function automatic logic [REQ_NUM-1:0] onehot(input logic [IdW-1:0] id);
    onehot     = '0;
    onehot[id] = 1'b1;
  endfunction

  ddr_rd_arbiter_rr_pick #(
    .REQ_NUM (REQ_NUM),
    .IdW     (IdW)
  ) u_rr_pick (
    .req_i (bus_io.req_valid),
    .ptr_i (rr_ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Mux the winning requester's descriptor out of the packed request buses.
  always_comb begin
    sel                 = 32'(pick_idx);
    pick_desc.st_addr   = bus_io.req_st_addr[sel*DDR_ADDR_W +: DDR_ADDR_W];
    pick_desc.burst     = bus_io.req_burst[sel*BURST_W +: BURST_W];
    pick_desc.step      = bus_io.req_step[sel*DDR_ADDR_W +: DDR_ADDR_W];
    pick_desc.burst_num = bus_io.req_burst_num[sel*BURST_W +: BURST_W];
  end

  // Arbitration FSM with all outputs registered; pulses default low each cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      desc_q      <= '0;
      ddr_start_q <= 1'b0;
      busy_q      <= 1'b0;
      req_ready_q <= '0;
      req_done_q  <= '0;
`ifdef DDR_ARB_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      ddr_start_q <= 1'b0;
      req_ready_q <= '0;
      req_done_q  <= '0;
      unique case (state_q)
        StIdle: begin
          if (pick_any) begin
            desc_q      <= pick_desc;
            grant_q     <= pick_idx;
            ddr_start_q <= 1'b1;
            req_ready_q <= onehot(pick_idx);
            busy_q      <= 1'b1;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          // A done already returned during the launch cycle skips BUSY.
          if (bus_io.ddr_done) begin
            req_done_q <= onehot(grant_q);
            state_q    <= StDone;
          end else begin
`ifdef DDR_ARB_TIMEOUT_EN
            tmo_cnt_q  <= '0;
`endif
            state_q    <= StBusy;
          end
        end
        StBusy: begin
          if (bus_io.ddr_done) begin
            req_done_q <= onehot(grant_q);
            state_q    <= StDone;
          end
`ifdef DDR_ARB_TIMEOUT_EN
          else if (tmo_cnt_q == CntW'(TIMEOUT - 1)) begin
            // Release the owner anyway so it cannot deadlock on a lost done.
            req_done_q <= onehot(grant_q);
            err_q      <= 1'b1;
            state_q    <= StDone;
          end else begin
            tmo_cnt_q  <= tmo_cnt_q + CntW'(1);
          end
`endif
        end
        StDone: begin
          rr_ptr_q <= grant_q + IdW'(1);
          busy_q   <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.ddr_start     = ddr_start_q;
  assign bus_io.req_ready     = req_ready_q;
  assign bus_io.req_done      = req_done_q;
  assign bus_io.ddr_st_addr   = desc_q.st_addr;
  assign bus_io.ddr_burst     = desc_q.burst;
  assign bus_io.ddr_step      = desc_q.step;
  assign bus_io.ddr_burst_num = desc_q.burst_num;
  assign bus_io.grant_id      = grant_q;
  assign bus_io.busy          = busy_q;
`ifdef DDR_ARB_TIMEOUT_EN
  assign bus_io.err_timeout   = err_q;
`else
  assign bus_io.err_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Directed self-checking bench for ddr_rd_arbiter (4 requesters, TIMEOUT=64).
module tb_ddr_rd_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  ddr_rd_arbiter_if #(.REQ_NUM(4)) bus ();

  ddr_rd_arbiter #(
    .REQ_NUM (4),
    .TIMEOUT (64)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  // Expected per-requester descriptors (requester 0 is the test-plan vector).
  function automatic logic [31:0] e_addr(input int i);
    return 32'h1000 + 32'(i) * 32'h1_0000;
  endfunction
  function automatic logic [7:0] e_burst(input int i);
    return 8'(16 + i);
  endfunction
  function automatic logic [31:0] e_step(input int i);
    return 32'h100 * 32'(i + 1);
  endfunction
  function automatic logic [7:0] e_bnum(input int i);
    return 8'(4 + i);
  endfunction

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the launch pulse and check grant and descriptor.
  task automatic wait_issue(input int exp, input logic [3:0] drop, input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      tick();
      if (bus.ddr_start) seen = 1'b1;
    end
    check_val({tag, "_start"}, 64'(seen), 64'd1);
    check_val({tag, "_grant"}, 64'(bus.grant_id), 64'(exp));
    check_val({tag, "_ready"}, 64'(bus.req_ready), 64'(4'b0001 << exp));
    check_val({tag, "_addr"}, 64'(bus.ddr_st_addr), 64'(e_addr(exp)));
    check_val({tag, "_burst"}, 64'(bus.ddr_burst), 64'(e_burst(exp)));
    check_val({tag, "_step"}, 64'(bus.ddr_step), 64'(e_step(exp)));
    check_val({tag, "_bnum"}, 64'(bus.ddr_burst_num), 64'(e_bnum(exp)));
    bus.req_valid = bus.req_valid & ~drop;
  endtask

  // Hold the engine busy for dly cycles, then return done and expect req_done.
  task automatic finish(input int exp, input int dly, input string tag);
    for (int k = 0; k < dly; k++) begin
      tick();
      check_val({tag, "_nostart"}, 64'(bus.ddr_start), 64'd0);
    end
    bus.ddr_done = 1'b1;
    tick();
    bus.ddr_done = 1'b0;
    check_val({tag, "_done"}, 64'(bus.req_done), 64'(4'b0001 << exp));
  endtask

  initial begin
    bus.req_valid = '0;
    bus.ddr_done  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.req_st_addr[i*32 +: 32]  = e_addr(i);
      bus.req_burst[i*8 +: 8]      = e_burst(i);
      bus.req_step[i*32 +: 32]     = e_step(i);
      bus.req_burst_num[i*8 +: 8]  = e_bnum(i);
    end

    // Reset state
    tick();
    tick();
    check_val("rst_busy", 64'(bus.busy), 64'd0);
    check_val("rst_start", 64'(bus.ddr_start), 64'd0);
    check_val("rst_ready", 64'(bus.req_ready), 64'd0);
    check_val("rst_done", 64'(bus.req_done), 64'd0);
    check_val("rst_grant", 64'(bus.grant_id), 64'd0);
    check_val("rst_addr", 64'(bus.ddr_st_addr), 64'd0);
    check_val("rst_err", 64'(bus.err_timeout), 64'd0);
    rst = 1'b1;
    tick();

    // Single request from requester 0
    bus.req_valid = 4'b0001;
    wait_issue(0, 4'b0001, "single");
    check_val("single_busy", 64'(bus.busy), 64'd1);
    finish(0, 6, "single");
    tick();
    check_val("single_idle", 64'(bus.busy), 64'd0);
    check_val("single_done_clr", 64'(bus.req_done), 64'd0);
    check_val("single_hold_addr", 64'(bus.ddr_st_addr), 64'h1000);

    // All four requesting continuously from reset: order 0,1,2,3,0
    rst = 1'b0;
    tick();
    rst = 1'b1;
    bus.req_valid = 4'b1111;
    wait_issue(0, 4'b0000, "rr0");
    finish(0, 2, "rr0");
    wait_issue(1, 4'b0000, "rr1");
    finish(1, 1, "rr1");
    wait_issue(2, 4'b0000, "rr2");
    finish(2, 3, "rr2");
    wait_issue(3, 4'b0000, "rr3");
    finish(3, 1, "rr3");
    wait_issue(0, 4'b1111, "rr4");
    finish(0, 2, "rr4");

    // Zero-latency done: req_done directly one cycle after the launch
    bus.req_valid = 4'b1000;
    wait_issue(3, 4'b1000, "zl");
    finish(3, 0, "zl");

    // Reset in the middle of BUSY, then a stray done
    bus.req_valid = 4'b0010;
    wait_issue(1, 4'b0010, "mid");
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b0;
    #1;
    check_val("mid_rst_busy", 64'(bus.busy), 64'd0);
    check_val("mid_rst_grant", 64'(bus.grant_id), 64'd0);
    check_val("mid_rst_addr", 64'(bus.ddr_st_addr), 64'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    bus.ddr_done = 1'b1;
    tick();
    bus.ddr_done = 1'b0;
    check_val("mid_spur_done", 64'(bus.req_done), 64'd0);
    check_val("mid_spur_busy", 64'(bus.busy), 64'd0);
    tick();
    check_val("mid_spur_done2", 64'(bus.req_done), 64'd0);
    // rr_ptr back at 0: requester 0 must win over 1..3
    bus.req_valid = 4'b1111;
    wait_issue(0, 4'b1111, "mid_ptr");
    finish(0, 1, "mid_ptr");

    // Withdrawal: requester 2 raised and dropped while 1 is served
    bus.req_valid = 4'b0010;
    wait_issue(1, 4'b0010, "wd");
    bus.req_valid[2] = 1'b1;
    tick();
    tick();
    bus.req_valid[2] = 1'b0;
    finish(1, 3, "wd");
    bus.req_valid = 4'b1001;
    wait_issue(3, 4'b1001, "wd_next");
    finish(3, 1, "wd_next");

    // Engine never answers
    bus.req_valid = 4'b0001;
    wait_issue(0, 4'b0001, "tmo");
`ifdef DDR_ARB_TIMEOUT_EN
    begin
      int  n_busy = 0;
      bit  hit    = 1'b0;
      for (int k = 0; k < 200 && !hit; k++) begin
        tick();
        if (bus.req_done != 4'b0000) hit = 1'b1;
        else n_busy++;
      end
      check_val("tmo_fired", 64'(hit), 64'd1);
      check_val("tmo_cycles", 64'(n_busy), 64'd64);
      check_val("tmo_done", 64'(bus.req_done), 64'h1);
      check_val("tmo_err", 64'(bus.err_timeout), 64'd1);
      tick();
      check_val("tmo_idle", 64'(bus.busy), 64'd0);
      check_val("tmo_sticky", 64'(bus.err_timeout), 64'd1);
    end
`else
    begin
      bit early = 1'b0;
      for (int k = 0; k < 100; k++) begin
        tick();
        if (bus.req_done != 4'b0000 || !bus.busy) early = 1'b1;
      end
      check_val("tmo_hold", 64'(early), 64'd0);
      check_val("tmo_busy", 64'(bus.busy), 64'd1);
      finish(0, 0, "tmo_late");
      check_val("tmo_err", 64'(bus.err_timeout), 64'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
